// File: rtl/pride_pkg.sv
// Shared flag-sequencer definitions: flag count, frame geometry, state encoding, index wrap.
// Also used by the stripe renderer and flag ROM.
package pride_pkg;

   localparam int unsigned NUM_FLAGS = 8;
   localparam int unsigned V_ACTIVE  = 480;
   localparam int unsigned WIPE_STEP = 8;
   localparam int unsigned IDX_W     = $clog2(NUM_FLAGS);

   typedef logic [IDX_W-1:0] flag_idx_t;

   typedef enum logic [1:0] {
      StShow,
      StCommit,
      StWipe
   } state_e;

   // Neighbouring flag index with wrap-around in both directions.
   function automatic flag_idx_t step_flag(flag_idx_t idx, logic dir_prev);
      flag_idx_t last;
      last = flag_idx_t'(NUM_FLAGS - 1);
      if (dir_prev) begin
         return (idx == '0) ? last : idx - 1'b1;
      end
      return (idx == last) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/pride_flag_sequencer_if.sv
// Control/status bundle between the flag sequencer (master) and its pads/renderer side (slave).
interface pride_flag_sequencer_if;

   logic                 frame_start;
   logic                 btn_next;
   logic                 btn_prev;
   logic                 auto_en;
   pride_pkg::flag_idx_t flag_idx;
   pride_pkg::flag_idx_t next_idx;
   logic                 flag_changed;
   logic                 wipe_active;
   logic [9:0]           wipe_line;

   modport master (
      input  frame_start, btn_next, btn_prev, auto_en,
      output flag_idx, next_idx, flag_changed, wipe_active, wipe_line
   );

   modport slave (
      output frame_start, btn_next, btn_prev, auto_en,
      input  flag_idx, next_idx, flag_changed, wipe_active, wipe_line
   );

endinterface

// File: rtl/frame_btn_edge.sv
// Pushbutton synchroniser plus frame-rate sampler; press pulses during a frame_start cycle
// when the button is newly seen high at that frame boundary.
module frame_btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic frame_start,
   input  logic btn,
   output logic press
);

   logic [1:0] sync_q;
   logic       prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         if (frame_start) begin
            prev_q <= sync_q[1];
         end
      end
   end

   assign press = frame_start & sync_q[1] & ~prev_q;

endmodule

// File: rtl/pride_flag_sequencer.sv
// Selects the displayed pride flag from buttons and an auto-cycle timer, committing on frame_start.
// Define PRIDE_FLAG_WIPE_EN to build the downward wipe transition instead of immediate changes.
module pride_flag_sequencer
   import pride_pkg::*;
#(
   parameter int unsigned AUTO_FRAMES = 300
) (
   input  logic                  clk,
   input  logic                  rst,
   pride_flag_sequencer_if.master bus
);

   localparam int unsigned CntW = $clog2(AUTO_FRAMES);

   logic            press_next;
   logic            press_prev;
   logic            manual_req;
   logic            auto_fire;
   logic            req_v;
   logic            req_prev;
   flag_idx_t       target;

   state_e          state_q;
   flag_idx_t       flag_idx_q;
   flag_idx_t       next_idx_q;
   logic            flag_changed_q;
   logic            pending_q;
   logic            pending_prev_q;
   logic [CntW-1:0] cnt_q;

   frame_btn_edge u_btn_next (
      .clk         (clk),
      .rst         (rst),
      .frame_start (bus.frame_start),
      .btn         (bus.btn_next),
      .press       (press_next)
   );

   frame_btn_edge u_btn_prev (
      .clk         (clk),
      .rst         (rst),
      .frame_start (bus.frame_start),
      .btn         (bus.btn_prev),
      .press       (press_prev)
   );

   // Simultaneous next+prev cancel; a fresh press overrides anything already pending.
   assign manual_req = press_next ^ press_prev;
   assign auto_fire  = bus.auto_en && bus.frame_start && (state_q == StShow) && !pending_q &&
                       !manual_req && (cnt_q == CntW'(AUTO_FRAMES - 1));
   assign req_v      = manual_req | pending_q | auto_fire;
   assign req_prev   = manual_req ? press_prev : (pending_q & pending_prev_q);
   assign target     = step_flag(flag_idx_q, req_prev);

`ifdef PRIDE_FLAG_WIPE_EN
   logic        wipe_active_q;
   logic [9:0]  wipe_line_q;
   logic [10:0] wipe_next;
   logic        wipe_done;

   assign wipe_next = {1'b0, wipe_line_q} + 11'(WIPE_STEP);
   assign wipe_done = wipe_next >= 11'(V_ACTIVE);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StShow;
         flag_idx_q     <= '0;
         next_idx_q     <= '0;
         flag_changed_q <= 1'b0;
         pending_q      <= 1'b0;
         pending_prev_q <= 1'b0;
         cnt_q          <= '0;
`ifdef PRIDE_FLAG_WIPE_EN
         wipe_active_q  <= 1'b0;
         wipe_line_q    <= '0;
`endif
      end else begin
         flag_changed_q <= 1'b0;

         if (!bus.auto_en || manual_req) begin
            cnt_q <= '0;
         end else if (bus.frame_start && (state_q == StShow) && !pending_q) begin
            cnt_q <= auto_fire ? '0 : cnt_q + 1'b1;
         end

         unique case (state_q)
            StShow: begin
               if (bus.frame_start && req_v) begin
                  pending_q <= 1'b0;
`ifdef PRIDE_FLAG_WIPE_EN
                  next_idx_q    <= target;
                  wipe_active_q <= 1'b1;
                  wipe_line_q   <= '0;
                  state_q       <= StWipe;
`else
                  flag_idx_q     <= target;
                  next_idx_q     <= target;
                  flag_changed_q <= 1'b1;
                  state_q        <= StCommit;
`endif
               end
            end
            StCommit: begin
               if (manual_req) begin
                  pending_q      <= 1'b1;
                  pending_prev_q <= press_prev;
               end
               state_q <= StShow;
            end
`ifdef PRIDE_FLAG_WIPE_EN
            StWipe: begin
               if (manual_req) begin
                  pending_q      <= 1'b1;
                  pending_prev_q <= press_prev;
               end
               if (bus.frame_start) begin
                  if (wipe_done) begin
                     flag_idx_q     <= next_idx_q;
                     flag_changed_q <= 1'b1;
                     wipe_active_q  <= 1'b0;
                     wipe_line_q    <= '0;
                     state_q        <= StShow;
                  end else begin
                     wipe_line_q <= wipe_next[9:0];
                  end
               end
            end
`endif
            default: state_q <= StShow;
         endcase
      end
   end

   assign bus.flag_idx     = flag_idx_q;
   assign bus.next_idx     = next_idx_q;
   assign bus.flag_changed = flag_changed_q;
`ifdef PRIDE_FLAG_WIPE_EN
   assign bus.wipe_active  = wipe_active_q;
   assign bus.wipe_line    = wipe_line_q;
`else
   assign bus.wipe_active  = 1'b0;
   assign bus.wipe_line    = '0;
`endif

endmodule
